// File: rtl/lightning_pkg.sv
// Shared types and constants for the lightning shot scheduler.
// Slot and arbiter state encodings, slot count, ammo width, slot picker.
package lightning_pkg;

    localparam int NUM_SLOTS = 3;
    localparam int AMMO_W    = 2;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_LAUNCH,
        SLOT_FLIGHT
    } slot_state_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_COOLDOWN
    } arb_state_t;

    // One-hot of the lowest set bit; zero when nothing is free.
    function automatic logic [NUM_SLOTS-1:0] pick_lowest(
        input logic [NUM_SLOTS-1:0] free
    );
        logic [NUM_SLOTS-1:0] r;
        r = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lightning_slot_tracker.sv
// Tracks one lightning slot: FREE -> LAUNCH -> FLIGHT -> FREE, with launch timeout.
// Ports: clk, resetN (async, active-high), restart, launch_bit, in_air -> free.
module lightning_slot_tracker
    import lightning_pkg::*;
#(
    parameter logic [15:0] LAUNCH_TIMEOUT = 16'd1024
) (
    input  logic clk,
    input  logic resetN,
    input  logic restart,
    input  logic launch_bit,
    input  logic in_air,
    output logic free
);

    slot_state_t state, state_nxt;
    logic [15:0] to_cnt;
    logic        timed_out;

    assign timed_out = (to_cnt == LAUNCH_TIMEOUT - 16'd1);

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            state <= SLOT_FREE;
        else if (restart)
            state <= SLOT_FREE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_FREE:
                if (launch_bit) state_nxt = SLOT_LAUNCH;
            SLOT_LAUNCH:
                if (in_air)         state_nxt = SLOT_FLIGHT;
                else if (timed_out) state_nxt = SLOT_FREE;
            SLOT_FLIGHT:
                if (!in_air) state_nxt = SLOT_FREE;
            default:
                state_nxt = SLOT_FREE;
        endcase
    end

    always_comb begin
        free = (state == SLOT_FREE);
    end

    // Counts cycles spent in LAUNCH waiting for the mover.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            to_cnt <= '0;
        else if (restart)
            to_cnt <= '0;
        else if (state == SLOT_LAUNCH && !in_air && !timed_out)
            to_cnt <= to_cnt + 16'd1;
        else
            to_cnt <= '0;
    end

endmodule

// File: rtl/lightning_shot_scheduler.sv
// Arbitrates shoot requests onto three lightning slots with cooldown and timed reload.
// Ports: clk, resetN, restart, shoot_pulse, slot_in_air -> launch, ammo, cooldown_busy, shot_denied.
module lightning_shot_scheduler
    import lightning_pkg::*;
#(
    parameter int          AMMO_MAX        = 3,
    parameter logic [31:0] COOLDOWN_CYCLES = 32'd5_000_000,
    parameter logic [31:0] RELOAD_CYCLES   = 32'd50_000_000,
    parameter logic [15:0] LAUNCH_TIMEOUT  = 16'd1024
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 restart,
    input  logic                 shoot_pulse,
    input  logic [NUM_SLOTS-1:0] slot_in_air,
    output logic [NUM_SLOTS-1:0] launch,
    output logic [AMMO_W-1:0]    ammo,
    output logic                 cooldown_busy,
    output logic                 shot_denied
);

    localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

    arb_state_t           arb, arb_nxt;
    logic [31:0]          cd_cnt;
    logic [31:0]          rl_cnt;
    logic [NUM_SLOTS-1:0] slot_free;
    logic [NUM_SLOTS-1:0] pick;
    logic                 accept;
    logic                 cd_done;
    logic                 rl_tick;
    logic                 ammo_low;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        lightning_slot_tracker #(
            .LAUNCH_TIMEOUT(LAUNCH_TIMEOUT)
        ) u_slot (
            .clk       (clk),
            .resetN    (resetN),
            .restart   (restart),
            .launch_bit(launch[i]),
            .in_air    (slot_in_air[i]),
            .free      (slot_free[i])
        );
    end

    assign pick     = pick_lowest(slot_free);
    assign ammo_low = (ammo != AMMO_FULL);
    assign cd_done  = (cd_cnt == COOLDOWN_CYCLES - 32'd1);
    assign rl_tick  = ammo_low && (rl_cnt == RELOAD_CYCLES - 32'd1);

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            arb <= ARB_IDLE;
        else if (restart)
            arb <= ARB_IDLE;
        else
            arb <= arb_nxt;
    end

    always_comb begin
        arb_nxt = arb;
        case (arb)
            ARB_IDLE:     if (accept)  arb_nxt = ARB_COOLDOWN;
            ARB_COOLDOWN: if (cd_done) arb_nxt = ARB_IDLE;
            default:                   arb_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        accept = (arb == ARB_IDLE) && shoot_pulse
              && (ammo != '0) && (|slot_free);
        cooldown_busy = (arb == ARB_COOLDOWN);
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            cd_cnt <= '0;
        else if (restart)
            cd_cnt <= '0;
        else if (arb == ARB_COOLDOWN && !cd_done)
            cd_cnt <= cd_cnt + 32'd1;
        else
            cd_cnt <= '0;
    end

    // Reload counter idles at 0 while full, clears on each tick.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            rl_cnt <= '0;
        else if (restart)
            rl_cnt <= '0;
        else if (ammo_low && !rl_tick)
            rl_cnt <= rl_cnt + 32'd1;
        else
            rl_cnt <= '0;
    end

    // A shot and a reload tick in the same cycle cancel out.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN)
            ammo <= AMMO_FULL;
        else if (restart)
            ammo <= AMMO_FULL;
        else if (accept && !rl_tick)
            ammo <= ammo - 1'b1;
        else if (rl_tick && !accept)
            ammo <= ammo + 1'b1;
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            launch      <= '0;
            shot_denied <= 1'b0;
        end else if (restart) begin
            launch      <= '0;
            shot_denied <= 1'b0;
        end else begin
            launch      <= accept ? pick : '0;
            shot_denied <= shoot_pulse && !accept;
        end
    end

endmodule

// File: tb/tb_lightning_shot_scheduler.sv
// Directed bench for lightning_shot_scheduler with shortened timing parameters.
// Edge labels in the stimulus count clock edges from the first shot of each scenario.
module tb_lightning_shot_scheduler;

    logic       clk = 1'b0;
    logic       resetN;
    logic       restart;
    logic       shoot_pulse;
    logic [2:0] slot_in_air;
    logic [2:0] launch;
    logic [1:0] ammo;
    logic       cooldown_busy;
    logic       shot_denied;

    int n_checks = 0;
    int n_errors = 0;

    lightning_shot_scheduler #(
        .AMMO_MAX       (3),
        .COOLDOWN_CYCLES(32'd8),
        .RELOAD_CYCLES  (32'd20),
        .LAUNCH_TIMEOUT (16'd4)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .restart      (restart),
        .shoot_pulse  (shoot_pulse),
        .slot_in_air  (slot_in_air),
        .launch       (launch),
        .ammo         (ammo),
        .cooldown_busy(cooldown_busy),
        .shot_denied  (shot_denied)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        shoot_pulse = 1'b0;
        slot_in_air = 3'b000;
        restart     = 1'b1;
        tick();
        restart     = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_launch"}, 32'(launch), 32'd0);
        check({tag, "_ammo"}, 32'(ammo), 32'd3);
        check({tag, "_busy"}, 32'(cooldown_busy), 32'd0);
        check({tag, "_denied"}, 32'(shot_denied), 32'd0);
        check({tag, "_free"}, 32'(dut.slot_free), 32'd7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN      = 1'b1;
        restart     = 1'b0;
        shoot_pulse = 1'b0;
        slot_in_air = 3'b000;
        #12;
        check_idle("reset");
        @(negedge clk);
        resetN = 1'b0;

        // Single shot, cooldown length, launch timeout
        shoot_pulse = 1'b1;
        tick();
        shoot_pulse = 1'b0;
        check("t1_launch", 32'(launch), 32'd1);
        check("t1_ammo", 32'(ammo), 32'd2);
        check("t1_busy0", 32'(cooldown_busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("t1_busy%0d", i), 32'(cooldown_busy),
                  (i < 8) ? 32'd1 : 32'd0);
            check($sformatf("t1_free%0d", i), 32'(dut.slot_free),
                  (i <= 4) ? 32'd6 : 32'd7);
            check($sformatf("t1_launch%0d", i), 32'(launch), 32'd0);
        end
        check("t1_ammo_end", 32'(ammo), 32'd2);

        // Shot during cooldown is rejected
        do_restart();
        check_idle("restart1");
        shoot_pulse = 1'b1;
        tick();
        shoot_pulse = 1'b0;
        tick();
        tick();
        shoot_pulse = 1'b1;
        tick();
        shoot_pulse = 1'b0;
        check("t3_denied", 32'(shot_denied), 32'd1);
        check("t3_launch", 32'(launch), 32'd0);
        check("t3_ammo", 32'(ammo), 32'd2);
        check("t3_busy", 32'(cooldown_busy), 32'd1);
        tick();
        check("t3_denied_clr", 32'(shot_denied), 32'd0);

        // Three shots into three slots, then reload and reuse
        do_restart();
        shoot_pulse = 1'b1;
        tick();                         // G0
        shoot_pulse = 1'b0;
        check("t2_l0", 32'(launch), 32'd1);
        check("t2_a0", 32'(ammo), 32'd2);
        slot_in_air = 3'b001;
        repeat (8) tick();              // G1..G8
        shoot_pulse = 1'b1;
        tick();                         // G9
        shoot_pulse = 1'b0;
        check("t2_l1", 32'(launch), 32'd2);
        check("t2_a1", 32'(ammo), 32'd1);
        slot_in_air = 3'b011;
        repeat (8) tick();              // G10..G17
        shoot_pulse = 1'b1;
        tick();                         // G18
        shoot_pulse = 1'b0;
        check("t2_l2", 32'(launch), 32'd4);
        check("t2_a2", 32'(ammo), 32'd0);
        slot_in_air = 3'b111;
        tick();                         // G19
        check("t5_ammo0", 32'(ammo), 32'd0);
        tick();                         // G20: reload tick
        check("t5_reload", 32'(ammo), 32'd1);
        repeat (6) tick();              // G21..G26
        shoot_pulse = 1'b1;
        tick();                         // G27: no free slot
        shoot_pulse = 1'b0;
        check("t2_deny_full", 32'(shot_denied), 32'd1);
        check("t2_deny_launch", 32'(launch), 32'd0);
        check("t2_deny_ammo", 32'(ammo), 32'd1);
        slot_in_air = 3'b110;
        tick();                         // G28
        check("t4_free", 32'(dut.slot_free), 32'd1);
        shoot_pulse = 1'b1;
        tick();                         // G29
        shoot_pulse = 1'b0;
        check("t4_reuse", 32'(launch), 32'd1);
        check("t4_ammo", 32'(ammo), 32'd0);
        repeat (10) tick();             // G30..G39
        check("t5_timeout", 32'(dut.slot_free), 32'd1);
        check("t5_ammo_empty", 32'(ammo), 32'd0);
        shoot_pulse = 1'b1;
        tick();                         // G40: empty, reload tick
        shoot_pulse = 1'b0;
        check("t5_deny_empty", 32'(shot_denied), 32'd1);
        check("t5_deny_launch", 32'(launch), 32'd0);
        check("t5_ammo_up", 32'(ammo), 32'd1);
        repeat (19) tick();             // G41..G59
        shoot_pulse = 1'b1;
        tick();                         // G60: shot on reload tick
        shoot_pulse = 1'b0;
        check("t5_tick_launch", 32'(launch), 32'd1);
        check("t5_tick_ammo", 32'(ammo), 32'd1);
        check("t5_tick_denied", 32'(shot_denied), 32'd0);
        tick();                         // G61
        check("t5_hold_ammo", 32'(ammo), 32'd1);
        check("t6_busy_pre", 32'(cooldown_busy), 32'd1);
        check("t6_free_pre", 32'(dut.slot_free), 32'd0);

        // Restart mid-cooldown with slots in flight
        restart = 1'b1;
        tick();                         // G62
        check_idle("t6_restart");
        shoot_pulse = 1'b1;
        tick();
        check("t6_hold_launch", 32'(launch), 32'd0);
        check("t6_hold_denied", 32'(shot_denied), 32'd0);
        check("t6_hold_ammo", 32'(ammo), 32'd3);
        restart     = 1'b0;
        shoot_pulse = 1'b1;
        slot_in_air = 3'b000;
        tick();
        shoot_pulse = 1'b0;
        check("t6_pre_launch", 32'(launch), 32'd1);
        check("t6_pre_ammo", 32'(ammo), 32'd2);

        // Asynchronous reset between edges
        #3;
        resetN = 1'b1;
        #1;
        check_idle("t6_async");
        @(negedge clk);
        resetN = 1'b0;
        tick();
        check_idle("t6_release");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
